// File: rtl/multi_cycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_control
// Description : Multi-cycle MIPS sequencing controller. Steps each instruction
//               through FETCH, DECODE and execute/memory/writeback states,
//               honours memory wait states, traps illegal instructions and
//               takes IRQ at instruction boundaries outside kernel mode.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_control #(
   parameter int ST_W = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [5:0]      OpCode,
   input  logic [5:0]      Funct,
   input  logic            IRQ,
   input  logic            ker,
   input  logic            MemReady,
   output logic            PCWrite,
   output logic            PCWriteCond,
   output logic            IorD,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            IRWrite,
   output logic            RegWrite,
   output logic [1:0]      RegDst,
   output logic [1:0]      MemtoReg,
   output logic [1:0]      ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [2:0]      ALUOp,
   output logic [2:0]      PCSource,
   output logic            EPCWrite,
   output logic [ST_W-1:0] state,
   output logic            instr_done
);

   typedef enum logic [ST_W-1:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      EXEC_I    = 4'd10,
      I_WB      = 4'd11,
      TRAP      = 4'd12
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   r_trap_exc;   // 1 = current TRAP is an illegal-instruction exception
   logic   w_trap_nxt;
   logic   w_end;        // final cycle of a normal instruction

   // Instruction classes, valid from DECODE onwards
   logic w_is_rtype, w_is_jr, w_is_shift, w_is_branch, w_is_jump, w_is_itype;
   logic w_is_mem, w_is_lw, w_is_jal, w_is_jalr;

   assign w_is_lw     = (OpCode == 6'h23);
   assign w_is_mem    = w_is_lw || (OpCode == 6'h2b);
   assign w_is_jr     = (OpCode == 6'h00) && (Funct == 6'h08 || Funct == 6'h09);
   assign w_is_jalr   = (OpCode == 6'h00) && (Funct == 6'h09);
   assign w_is_shift  = (Funct == 6'h00) || (Funct == 6'h02) || (Funct == 6'h03);
   assign w_is_rtype  = (OpCode == 6'h00) &&
                        (w_is_shift || (Funct[5:3] == 3'b100) || (Funct == 6'h2a));
   assign w_is_branch = (OpCode == 6'h01) || (OpCode[5:2] == 4'b0001);
   assign w_is_jump   = (OpCode == 6'h02) || (OpCode == 6'h03);
   assign w_is_jal    = (OpCode == 6'h03);
   assign w_is_itype  = ((OpCode >= 6'h08) && (OpCode <= 6'h0c)) || (OpCode == 6'h0f);

   assign state = r_state;

   // State and trap-cause registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= FETCH;
         r_trap_exc <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_trap_exc <= w_trap_nxt;
      end
   end

   // Next-state selection and per-state control outputs
   always_comb begin
      w_next      = r_state;
      w_trap_nxt  = r_trap_exc;
      w_end       = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 2'd0;
      MemtoReg    = 2'd0;
      ALUSrcA     = 2'd0;
      ALUSrcB     = 2'd0;
      ALUOp       = 3'd0;
      PCSource    = 3'd0;
      EPCWrite    = 1'b0;
      instr_done  = 1'b0;

      case (r_state)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'd1;
            if (MemReady) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               w_next  = DECODE;
            end
         end
         DECODE: begin
            // Branch target is precomputed into ALUOut here
            ALUSrcB = 2'd3;
            if (w_is_mem)         w_next = MEM_ADDR;
            else if (w_is_jr)     w_next = JUMP;
            else if (w_is_rtype)  w_next = EXEC_R;
            else if (w_is_branch) w_next = BRANCH;
            else if (w_is_jump)   w_next = JUMP;
            else if (w_is_itype)  w_next = EXEC_I;
            else begin
               w_next     = TRAP;
               w_trap_nxt = 1'b1;
            end
         end
         MEM_ADDR: begin
            ALUSrcA = 2'd1;
            ALUSrcB = 2'd2;
            w_next  = w_is_lw ? MEM_READ : MEM_WRITE;
         end
         MEM_READ: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (MemReady) w_next = MEM_WB;
         end
         MEM_WB: begin
            RegWrite = 1'b1;
            RegDst   = 2'd1;
            MemtoReg = 2'd1;
            w_end    = 1'b1;
         end
         MEM_WRITE: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            w_end    = MemReady;
         end
         EXEC_R: begin
            ALUSrcA = w_is_shift ? 2'd2 : 2'd1;
            ALUOp   = 3'd2;
            w_next  = R_WB;
         end
         R_WB: begin
            RegWrite = 1'b1;
            w_end    = 1'b1;
         end
         EXEC_I: begin
            ALUSrcA = 2'd1;
            ALUSrcB = 2'd2;
            ALUOp   = 3'd3;
            w_next  = I_WB;
         end
         I_WB: begin
            RegWrite = 1'b1;
            RegDst   = 2'd1;
            w_end    = 1'b1;
         end
         BRANCH: begin
            ALUSrcA     = 2'd1;
            ALUOp       = 3'd1;
            PCWriteCond = 1'b1;
            PCSource    = 3'd1;
            w_end       = 1'b1;
         end
         JUMP: begin
            PCWrite  = 1'b1;
            PCSource = w_is_jump ? 3'd2 : 3'd3;
            if (w_is_jal) begin
               RegWrite = 1'b1;
               RegDst   = 2'd2;
               MemtoReg = 2'd2;
            end else if (w_is_jalr) begin
               RegWrite = 1'b1;
               MemtoReg = 2'd2;
            end
            w_end = 1'b1;
         end
         TRAP: begin
            EPCWrite   = 1'b1;
            RegWrite   = 1'b1;
            RegDst     = 2'd3;
            MemtoReg   = 2'd2;
            PCWrite    = 1'b1;
            PCSource   = r_trap_exc ? 3'd5 : 3'd4;
            instr_done = 1'b1;
            w_next     = FETCH;
         end
         default: w_next = FETCH;
      endcase

      // Instruction boundary: the only point where IRQ is sampled
      if (w_end) begin
         instr_done = 1'b1;
         if (IRQ && !ker) begin
            w_next     = TRAP;
            w_trap_nxt = 1'b0;
         end else begin
            w_next = FETCH;
         end
      end

      // Reset silences every request, write and select
      if (reset) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IorD        = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         RegWrite    = 1'b0;
         RegDst      = 2'd0;
         MemtoReg    = 2'd0;
         ALUSrcA     = 2'd0;
         ALUSrcB     = 2'd0;
         ALUOp       = 3'd0;
         PCSource    = 3'd0;
         EPCWrite    = 1'b0;
         instr_done  = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_control
// Description : Scoreboard bench for multi_cycle_control. A reference model
//               expands each instruction into its expected per-cycle control
//               vectors; a driver applies inputs and queues expectations; a
//               monitor compares DUT outputs against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_control;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] OpCode = '0, Funct = '0;
   logic       IRQ = 1'b0, ker = 1'b0, MemReady = 1'b0;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
   logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB;
   logic [2:0] ALUOp, PCSource;
   logic       EPCWrite, instr_done;
   logic [3:0] state;

   multi_cycle_control #(.ST_W(4)) dut (
      .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .IRQ(IRQ),
      .ker(ker), .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .EPCWrite(EPCWrite),
      .state(state), .instr_done(instr_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcw, pcwc, iord, mrd, mwr, irw, rw;
      logic [1:0] regdst, memtoreg, srca, srcb;
      logic [2:0] aluop, pcsrc;
      logic       epcw;
      logic [3:0] st;
      logic       done;
   } outs_t;

   typedef struct {
      logic       rst;
      logic [5:0] op, fn;
      logic       irq, ker, mrdy;
      outs_t      exp;
   } cyc_t;

   cyc_t  plan[$];
   outs_t sb[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   int    cyc_no   = 0;

   logic [5:0] c_op, c_fn;
   logic       c_ker;

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   function automatic outs_t blank(input int st);
      outs_t o = '0;
      o.st = st[3:0];
      return o;
   endfunction

   task automatic add(input outs_t e, input logic mrdy, input logic irq, input logic rst);
      cyc_t c;
      c.rst = rst; c.op = c_op; c.fn = c_fn; c.ker = c_ker;
      c.irq = irq; c.mrdy = mrdy; c.exp = e;
      plan.push_back(c);
   endtask

   function automatic outs_t trap_vec(input logic exc);
      outs_t o = blank(12);
      o.epcw = 1; o.rw = 1; o.regdst = 2'd3; o.memtoreg = 2'd2;
      o.pcw = 1; o.pcsrc = exc ? 3'd5 : 3'd4; o.done = 1;
      return o;
   endfunction

   // Last cycle of a normal instruction: done pulse, then IRQ decides on a trap
   task automatic finish_instr(input outs_t o, input logic mrdy, input int irqm);
      logic irq;
      irq    = (irqm == 2) ? rb() : irqm[0];
      o.done = 1;
      add(o, mrdy, irq, 1'b0);
      if (irq && !c_ker) add(trap_vec(1'b0), rb(), rb(), 1'b0);
   endtask

   task automatic fetch_cycles(input int fw);
      outs_t o;
      repeat (fw) begin
         o = blank(0); o.mrd = 1; o.srcb = 2'd1;
         add(o, 1'b0, rb(), 1'b0);
      end
      o = blank(0); o.mrd = 1; o.srcb = 2'd1; o.irw = 1; o.pcw = 1;
      add(o, 1'b1, rb(), 1'b0);
   endtask

   // Reference model: expected cycle-by-cycle behaviour of one instruction
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic k,
                        input int fw, input int mw, input int irqm);
      outs_t o;
      c_op = op; c_fn = fn; c_ker = k;
      fetch_cycles(fw);
      o = blank(1); o.srcb = 2'd3;
      add(o, rb(), rb(), 1'b0);
      if (op == 6'h23 || op == 6'h2b) begin
         o = blank(2); o.srca = 2'd1; o.srcb = 2'd2;
         add(o, rb(), rb(), 1'b0);
         if (op == 6'h23) begin
            for (int i = 0; i <= mw; i++) begin
               o = blank(3); o.mrd = 1; o.iord = 1;
               add(o, (i == mw), rb(), 1'b0);
            end
            o = blank(4); o.rw = 1; o.regdst = 2'd1; o.memtoreg = 2'd1;
            finish_instr(o, rb(), irqm);
         end else begin
            for (int i = 0; i < mw; i++) begin
               o = blank(5); o.mwr = 1; o.iord = 1;
               add(o, 1'b0, rb(), 1'b0);
            end
            o = blank(5); o.mwr = 1; o.iord = 1;
            finish_instr(o, 1'b1, irqm);
         end
      end else if ((op == 6'h00 && fn inside {6'h08, 6'h09}) || op inside {6'h02, 6'h03}) begin
         o = blank(9); o.pcw = 1;
         o.pcsrc = (op == 6'h00) ? 3'd3 : 3'd2;
         if (op == 6'h03) begin o.rw = 1; o.regdst = 2'd2; o.memtoreg = 2'd2; end
         if (op == 6'h00 && fn == 6'h09) begin o.rw = 1; o.memtoreg = 2'd2; end
         finish_instr(o, rb(), irqm);
      end else if (op == 6'h00 && fn inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27], 6'h2a}) begin
         o = blank(6); o.srca = (fn inside {6'h00, 6'h02, 6'h03}) ? 2'd2 : 2'd1; o.aluop = 3'd2;
         add(o, rb(), rb(), 1'b0);
         o = blank(7); o.rw = 1;
         finish_instr(o, rb(), irqm);
      end else if (op inside {6'h01, [6'h04:6'h07]}) begin
         o = blank(8); o.srca = 2'd1; o.aluop = 3'd1; o.pcwc = 1; o.pcsrc = 3'd1;
         finish_instr(o, rb(), irqm);
      end else if (op inside {[6'h08:6'h0c], 6'h0f}) begin
         o = blank(10); o.srca = 2'd1; o.srcb = 2'd2; o.aluop = 3'd3;
         add(o, rb(), rb(), 1'b0);
         o = blank(11); o.rw = 1; o.regdst = 2'd1;
         finish_instr(o, rb(), irqm);
      end else begin
         add(trap_vec(1'b1), rb(), rb(), 1'b0);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation
   always @(negedge clk) begin
      outs_t act, e;
      if (sb.size() > 0) begin
         e   = sb.pop_front();
         act = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                 RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, EPCWrite,
                 state, instr_done};
         n_checks++;
         if (act === e) n_pass++;
         else $display("FAIL ctrl cycle %0d: got %h (state %0d) expected %h (state %0d)",
                       cyc_no, act, act.st, e, e.st);
         cyc_no++;
      end
   end

   initial begin
      int ops[] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 15, 'h23, 'h2b, 'h23, 'h2b, -1};
      int fns[] = '{0, 2, 3, 8, 9, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2a, -1};
      cyc_t  c;
      outs_t o;
      logic [5:0] op, fn;

      // Reset state check while reset is still asserted
      c_op = 0; c_fn = 0; c_ker = 0;
      add(blank(0), rb(), rb(), 1'b1);

      // Directed cases
      build(6'h00, 6'h21, 1'b0, 0, 0, 0);   // addu
      build(6'h23, 6'h00, 1'b0, 0, 2, 0);   // lw, two wait states
      build(6'h00, 6'h00, 1'b0, 0, 0, 0);   // sll
      build(6'h03, 6'h00, 1'b0, 0, 0, 0);   // jal
      build(6'h3f, 6'h00, 1'b0, 0, 0, 0);   // illegal
      build(6'h04, 6'h00, 1'b0, 0, 0, 1);   // beq + IRQ
      build(6'h04, 6'h00, 1'b1, 0, 0, 1);   // beq + IRQ, kernel mode
      build(6'h00, 6'h09, 1'b0, 1, 0, 0);   // jalr
      build(6'h2b, 6'h00, 1'b0, 0, 1, 1);   // sw + IRQ

      // Randomized instruction stream
      for (int n = 0; n < 150; n++) begin
         op = (ops[$urandom_range(0, ops.size() - 1)] < 0) ? 6'($urandom)
              : 6'(ops[$urandom_range(0, ops.size() - 1)]);
         fn = (fns[$urandom_range(0, fns.size() - 1)] < 0) ? 6'($urandom)
              : 6'(fns[$urandom_range(0, fns.size() - 1)]);
         build(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 3), 2);
      end

      // sw aborted by reset in its second wait cycle
      c_op = 6'h2b; c_fn = 0; c_ker = 0;
      fetch_cycles(0);
      o = blank(1); o.srcb = 2'd3; add(o, 1'b1, 1'b0, 1'b0);
      o = blank(2); o.srca = 2'd1; o.srcb = 2'd2; add(o, 1'b1, 1'b0, 1'b0);
      o = blank(5); o.mwr = 1; o.iord = 1; add(o, 1'b0, 1'b0, 1'b0);
      add(blank(5), 1'b0, 1'b1, 1'b1);
      build(6'h00, 6'h20, 1'b0, 2, 0, 0);

      // Driver
      repeat (2) @(posedge clk);
      foreach (plan[i]) begin
         @(posedge clk);
         #1;
         c        = plan[i];
         reset    = c.rst;
         OpCode   = c.op;
         Funct    = c.fn;
         IRQ      = c.irq;
         ker      = c.ker;
         MemReady = c.mrdy;
         sb.push_back(c.exp);
      end
      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard drain: got %0d left expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
